// File: rtl/result_serializer.sv
// Captures the accelerator's parallel class scores on a rising acc_ready and streams them
// one per valid/ready handshake, tracking a running signed argmax over the frame.
module result_serializer #(
  parameter int DATA_W      = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          acc_ready,
  input  logic [NUM_CLASSES*DATA_W-1:0] result_flat,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [IDX_W-1:0]              out_index,
  output logic                          out_last,
  output logic [IDX_W-1:0]              argmax,
  output logic                          argmax_valid,
  output logic                          busy,
  output logic                          overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t                   state, state_nxt;
  logic                     acc_ready_q;
  logic                     rise;
  logic [DATA_W-1:0]        shadow [NUM_CLASSES];
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         amax;
  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] cur;
  logic                     handshake;
  logic                     last;
  logic                     take;

  assign rise      = acc_ready & ~acc_ready_q;
  assign cur       = shadow[idx];
  assign last      = (idx == LAST_IDX);
  assign handshake = (state == STREAM) & out_ready;
  // Strict compare keeps the lowest index on ties; word 0 always seeds the running max.
  assign take      = (idx == '0) || (cur > max_q);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) state_nxt = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = cur;
        out_index = idx;
        out_last  = last;
        if (handshake && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the high reset value makes a level already high at release look like "no edge".
      acc_ready_q  <= 1'b1;
      idx          <= '0;
      amax         <= '0;
      max_q        <= '0;
      argmax       <= '0;
      argmax_valid <= 1'b0;
      overrun      <= 1'b0;
      // NOTE: the shadow bank is small and must read as zero after reset, so it is reset
      // explicitly rather than left to power-up contents.
      for (int k = 0; k < NUM_CLASSES; k++) shadow[k] <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every read sees the
      // pre-edge value regardless of statement order.
      acc_ready_q <= acc_ready;

      if (state == IDLE && rise) begin
        for (int k = 0; k < NUM_CLASSES; k++) shadow[k] <= result_flat[k*DATA_W +: DATA_W];
        idx          <= '0;
        argmax_valid <= 1'b0;
      end

      if (state == STREAM && rise) overrun <= 1'b1;

      if (handshake) begin
        if (take) begin
          max_q <= cur;
          amax  <= idx;
        end
        if (last) begin
          argmax       <= take ? idx : amax;
          argmax_valid <= 1'b1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Randomized self-checking bench for result_serializer; expected words and argmax come from
// the captured frame array and a lowest-index-of-maximum search.
module tb_result_serializer;

  localparam int DATA_W      = 32;
  localparam int NUM_CLASSES = 10;
  localparam int IDX_W       = 4;

  typedef logic signed [DATA_W-1:0] frame_t [NUM_CLASSES];

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          acc_ready;
  logic [NUM_CLASSES*DATA_W-1:0] result_flat;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_W-1:0]             out_data;
  logic [IDX_W-1:0]              out_index;
  logic                          out_last;
  logic [IDX_W-1:0]              argmax;
  logic                          argmax_valid;
  logic                          busy;
  logic                          overrun;

  int errors = 0;
  int checks = 0;

  result_serializer #(.DATA_W(DATA_W), .NUM_CLASSES(NUM_CLASSES), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .acc_ready(acc_ready), .result_flat(result_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .argmax(argmax),
    .argmax_valid(argmax_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Lowest index holding the maximum signed score.
  function automatic int ref_argmax(input frame_t sc);
    int best = 0;
    for (int i = 1; i < NUM_CLASSES; i++) if (sc[i] > sc[best]) best = i;
    return best;
  endfunction

  function automatic frame_t random_frame();
    frame_t      sc;
    logic [31:0] v;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if ($urandom_range(0, 1) == 1) v = $urandom_range(0, 6) - 3;  // small values force ties
      else                           v = $urandom();
      sc[i] = v;
    end
    return sc;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input frame_t sc);
    out_ready = 1'b0;
    acc_ready = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_before_capture: out_valid=%b want 0", out_valid);
    end
    for (int k = 0; k < NUM_CLASSES; k++) result_flat[k*DATA_W +: DATA_W] = sc[k];
    acc_ready = 1'b1;
    step();
    result_flat = {NUM_CLASSES{$urandom()}};
  endtask

  // Consumes one captured frame; optionally injects a second rise or a reset at a word.
  task automatic run_frame(input frame_t sc, input int stall_pct, input int rise_at,
                           input int reset_at, input logic exp_overrun);
    int k   = 0;
    int cyc = 0;
    bit rose = 1'b0;
    acc_ready = 1'b0;
    while (k < NUM_CLASSES && cyc < 400) begin
      if (k == reset_at) begin
        reset     = 1'b0;
        out_ready = 1'b0;
        step();
        checks++;
        if ({out_valid, busy, argmax_valid, overrun} !== 4'b0000) begin
          errors++;
          $display("FAIL reset_midstream: valid/busy/amv/ovr=%b want 0000",
                   {out_valid, busy, argmax_valid, overrun});
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
          step();
          checks++;
          if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_word: out_valid=%b idx=%0d want 0", out_valid, out_index);
          end
        end
        return;
      end
      checks++;
      if ({out_valid, busy, out_index, out_last, argmax_valid} !==
          {1'b1, 1'b1, IDX_W'(k), (k == NUM_CLASSES - 1), 1'b0}) begin
        errors++;
        $display("FAIL word_ctrl k=%0d: valid=%b busy=%b idx=%0d last=%b amv=%b want 1 1 %0d %b 0",
                 k, out_valid, busy, out_index, out_last, argmax_valid, k, k == NUM_CLASSES - 1);
      end
      checks++;
      if (out_data !== sc[k]) begin
        errors++;
        $display("FAIL word_data k=%0d: got %h want %h", k, out_data, sc[k]);
      end
      if (k == rise_at && !rose) begin
        acc_ready   = 1'b1;
        result_flat = {NUM_CLASSES{$urandom()}};
        rose        = 1'b1;
      end
      out_ready = ($urandom_range(0, 99) >= stall_pct);
      step();
      cyc++;
      if (out_ready) k++;
    end
    out_ready = 1'b0;
    checks++;
    if (k < NUM_CLASSES) begin
      errors++;
      $display("FAIL stream_timeout: words=%0d want %0d", k, NUM_CLASSES);
    end
    checks++;
    if ({out_valid, busy, argmax_valid, overrun} !== {1'b0, 1'b0, 1'b1, exp_overrun}) begin
      errors++;
      $display("FAIL frame_end: valid/busy/amv/ovr=%b want 001%b",
               {out_valid, busy, argmax_valid, overrun}, exp_overrun);
    end
    checks++;
    if (argmax !== IDX_W'(ref_argmax(sc))) begin
      errors++;
      $display("FAIL argmax: got %0d want %0d", argmax, ref_argmax(sc));
    end
  endtask

  function automatic frame_t frame_one();
    frame_t sc = '{5, -3, 7, 7, 0, -1, 2, 1, -8, 6};
    return sc;
  endfunction

  task automatic test_reset();
    reset = 1'b0; acc_ready = 1'b0; out_ready = 1'b0; result_flat = '0;
    step(); step();
    checks++;
    if ({out_valid, out_last, busy, argmax_valid, overrun, out_data, out_index, argmax} !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%b l=%b b=%b amv=%b ovr=%b d=%h i=%0d am=%0d want all 0",
               out_valid, out_last, busy, argmax_valid, overrun, out_data, out_index, argmax);
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    start_frame(frame_one());
    run_frame(frame_one(), 0, -1, -1, 1'b0);
    checks++;
    if (argmax !== 4'd2) begin
      errors++;
      $display("FAIL tie_lowest_index: got %0d want 2", argmax);
    end
  endtask

  task automatic test_stall();
    start_frame(frame_one());
    run_frame(frame_one(), 45, -1, -1, 1'b0);
  endtask

  task automatic test_signed();
    frame_t sc;
    for (int i = 0; i < NUM_CLASSES; i++) sc[i] = 32'h8000_0000;
    sc[NUM_CLASSES-1] = -1;
    start_frame(sc);
    run_frame(sc, 20, -1, -1, 1'b0);
  endtask

  task automatic test_ready_at_reset();
    frame_t sc = random_frame();
    reset = 1'b0; acc_ready = 1'b1;
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL level_at_release: valid=%b busy=%b want 0 0", out_valid, busy);
      end
    end
    start_frame(sc);
    run_frame(sc, 25, -1, -1, 1'b0);
  endtask

  task automatic test_overrun();
    frame_t sc = random_frame();
    start_frame(sc);
    run_frame(sc, 0, 4, -1, 1'b1);
  endtask

  task automatic test_back_to_back(input logic exp_overrun);
    for (int f = 0; f < 4; f++) begin
      frame_t sc = random_frame();
      start_frame(sc);
      run_frame(sc, 30, -1, -1, exp_overrun);
    end
  endtask

  task automatic test_reset_midstream();
    frame_t sc = random_frame();
    start_frame(sc);
    run_frame(sc, 20, -1, 6, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_signed();
    test_ready_at_reset();
    test_overrun();
    test_back_to_back(1'b1);
    test_reset_midstream();
    test_back_to_back(1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
